// File: rtl/inst_decode_pkg.sv
// inst_decode_pkg: shared widths, field positions, opcodes and control types for the decode stage
package inst_decode_pkg;
    localparam int REG       = 32;
    localparam int REG_FIELD = 5;
    localparam int OP        = 7;
    localparam int FUNCT_3   = 3;
    localparam int FUNCT_7   = 7;
    localparam int NUM_REGS  = 1 << REG_FIELD;
    localparam int OP_LSB      = 0;
    localparam int RD_LSB      = 7;
    localparam int FUNCT_3_LSB = 12;
    localparam int RS1_LSB     = 15;
    localparam int RS2_LSB     = 20;
    localparam int FUNCT_7_LSB = 25;

    typedef enum logic [OP-1:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_R3     = 7'b0110011
    } opcode_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef struct packed {
        logic    jump_sel;
        logic    mem_we;
        logic    op1_sel;
        logic    op2_sel;
        logic    reg_we;
        wb_sel_e wb_sel;
    } ctrl_t;
endpackage

// File: rtl/inst_decode_reg_file.sv
// inst_decode_reg_file: 32x32 register file
//   i_clk, i_rst_n        : clock, async active-low clear of all registers
//   i_we, i_waddr, i_wdata: synchronous write port (x0 writes dropped)
//   i_raddr1/2, o_rdata1/2: async read ports
//   i_dbg_en, i_dbg_addr, o_dbg_data: async debug read, 0 when disabled
module inst_decode_reg_file
    import inst_decode_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_we,
    input  logic [REG_FIELD-1:0] i_waddr,
    input  logic [REG-1:0]       i_wdata,
    input  logic [REG_FIELD-1:0] i_raddr1,
    input  logic [REG_FIELD-1:0] i_raddr2,
    input  logic                 i_dbg_en,
    input  logic [REG_FIELD-1:0] i_dbg_addr,
    output logic [REG-1:0]       o_rdata1,
    output logic [REG-1:0]       o_rdata2,
    output logic [REG-1:0]       o_dbg_data
);
    logic [REG-1:0] r_regs [0:NUM_REGS-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (i_we && i_waddr != '0) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // x0 is forced to read zero so it never depends on its storage cell
    assign o_rdata1   = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
    assign o_rdata2   = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];
    assign o_dbg_data = (!i_dbg_en || i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];
endmodule

// File: rtl/inst_decode.sv
// inst_decode: RV32I decode stage - field split, immediate, control selects, regfile and write-back
//   clk, reset      : clock, async active-low register file clear
//   instruction     : fetched instruction; pc_4/data_mem/alu_out feed the write-back mux
//   debug_en/addr   : debug register read port, debug_data=0 when disabled
//   opcode..rd, imm : decoded fields and sign-extended immediate
//   rs1/rs2_data    : register operands
//   jump_sel, mem_we, op1_sel, op2_sel : datapath control
module inst_decode
    import inst_decode_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 debug_en,
    input  logic [REG-1:0]       instruction,
    input  logic [REG-1:0]       pc_4,
    input  logic [REG-1:0]       data_mem,
    input  logic [REG-1:0]       alu_out,
    input  logic [REG_FIELD-1:0] debug_addr,
    output logic [OP-1:0]        opcode,
    output logic [FUNCT_3-1:0]   funct3,
    output logic [FUNCT_7-1:0]   funct7,
    output logic [REG_FIELD-1:0] rs1,
    output logic [REG_FIELD-1:0] rs2,
    output logic [REG_FIELD-1:0] rd,
    output logic [REG-1:0]       imm,
    output logic [REG-1:0]       rs1_data,
    output logic [REG-1:0]       rs2_data,
    output logic [REG-1:0]       debug_data,
    output logic                 jump_sel,
    output logic                 mem_we,
    output logic                 op1_sel,
    output logic                 op2_sel
);
    logic [REG-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_wb_data;
    ctrl_t          w_ctrl;

    assign opcode = instruction[OP_LSB      +: OP];
    assign rd     = instruction[RD_LSB      +: REG_FIELD];
    assign funct3 = instruction[FUNCT_3_LSB +: FUNCT_3];
    assign rs1    = instruction[RS1_LSB     +: REG_FIELD];
    assign rs2    = instruction[RS2_LSB     +: REG_FIELD];
    assign funct7 = instruction[FUNCT_7_LSB +: FUNCT_7];

    assign w_imm_i = {{20{instruction[31]}}, instruction[31:20]};
    assign w_imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign w_imm_b = {{19{instruction[31]}}, instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0};
    assign w_imm_u = {instruction[31:12], 12'b0};
    assign w_imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0};

    always_comb begin
        w_ctrl = '0;
        imm    = '0;
        case (opcode)
            OP_LUI:    begin imm = w_imm_u; w_ctrl.op2_sel = 1'b1; w_ctrl.reg_we = 1'b1; end
            OP_AUIPC:  begin imm = w_imm_u; w_ctrl.op1_sel = 1'b1; w_ctrl.op2_sel = 1'b1; w_ctrl.reg_we = 1'b1; end
            OP_JAL:    begin imm = w_imm_j; w_ctrl.jump_sel = 1'b1; w_ctrl.op1_sel = 1'b1; w_ctrl.op2_sel = 1'b1; w_ctrl.reg_we = 1'b1; w_ctrl.wb_sel = WB_PC4; end
            OP_JALR:   begin imm = w_imm_i; w_ctrl.jump_sel = 1'b1; w_ctrl.op2_sel = 1'b1; w_ctrl.reg_we = 1'b1; w_ctrl.wb_sel = WB_PC4; end
            OP_BRANCH: begin imm = w_imm_b; w_ctrl.op1_sel = 1'b1; end
            OP_LOAD:   begin imm = w_imm_i; w_ctrl.op2_sel = 1'b1; w_ctrl.reg_we = 1'b1; w_ctrl.wb_sel = WB_MEM; end
            OP_STORE:  begin imm = w_imm_s; w_ctrl.mem_we = 1'b1; w_ctrl.op2_sel = 1'b1; end
            OP_IMM:    begin imm = w_imm_i; w_ctrl.op2_sel = 1'b1; w_ctrl.reg_we = 1'b1; end
            OP_R3:     begin w_ctrl.reg_we = 1'b1; end
            default:   ;
        endcase
    end

    assign jump_sel  = w_ctrl.jump_sel;
    assign mem_we    = w_ctrl.mem_we;
    assign op1_sel   = w_ctrl.op1_sel;
    assign op2_sel   = w_ctrl.op2_sel;
    assign w_wb_data = (w_ctrl.wb_sel == WB_PC4) ? pc_4 :
                       (w_ctrl.wb_sel == WB_MEM) ? data_mem : alu_out;

    inst_decode_reg_file u_reg_file (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_we       (w_ctrl.reg_we),
        .i_waddr    (rd),
        .i_wdata    (w_wb_data),
        .i_raddr1   (rs1),
        .i_raddr2   (rs2),
        .i_dbg_en   (debug_en),
        .i_dbg_addr (debug_addr),
        .o_rdata1   (rs1_data),
        .o_rdata2   (rs2_data),
        .o_dbg_data (debug_data)
    );
endmodule

// File: tb/tb_inst_decode.sv
// tb_inst_decode: table-driven decode checks plus write-back and reset sequences for inst_decode
module tb_inst_decode;
    logic        clk = 1'b0, reset = 1'b0, debug_en = 1'b1;
    logic [31:0] instruction = '0, pc_4 = '0, data_mem = '0, alu_out = '0;
    logic [4:0]  debug_addr = '0;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, rs1_data, rs2_data, debug_data;
    logic        jump_sel, mem_we, op1_sel, op2_sel;
    int          errors = 0, checks = 0;

    inst_decode dut (
        .clk(clk), .reset(reset), .debug_en(debug_en), .instruction(instruction),
        .pc_4(pc_4), .data_mem(data_mem), .alu_out(alu_out), .debug_addr(debug_addr),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd),
        .imm(imm), .rs1_data(rs1_data), .rs2_data(rs2_data), .debug_data(debug_data),
        .jump_sel(jump_sel), .mem_we(mem_we), .op1_sel(op1_sel), .op2_sel(op2_sel)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [31:0] instr;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  s1, s2, d;
        logic [31:0] im;
        logic [3:0]  ctl;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg(input string name, input logic [4:0] a, input logic [31:0] exp);
        debug_addr = a;
        #1;
        chk(name, debug_data, exp);
    endtask

    initial begin
        // ctl = {jump_sel, mem_we, op1_sel, op2_sel}
        vecs[0]  = '{32'h00500093, 7'h13, 3'd0, 7'h00, 5'd0,  5'd5,  5'd1,  32'h00000005, 4'b0001};
        vecs[1]  = '{32'hFE20AE23, 7'h23, 3'd2, 7'h7F, 5'd1,  5'd2,  5'd28, 32'hFFFFFFFC, 4'b0101};
        vecs[2]  = '{32'h008000EF, 7'h6F, 3'd0, 7'h00, 5'd0,  5'd8,  5'd1,  32'h00000008, 4'b1011};
        vecs[3]  = '{32'h123452B7, 7'h37, 3'd5, 7'h09, 5'd8,  5'd3,  5'd5,  32'h12345000, 4'b0001};
        vecs[4]  = '{32'hFE208CE3, 7'h63, 3'd0, 7'h7F, 5'd1,  5'd2,  5'd25, 32'hFFFFFFF8, 4'b0010};
        vecs[5]  = '{32'h002081B3, 7'h33, 3'd0, 7'h00, 5'd1,  5'd2,  5'd3,  32'h00000000, 4'b0000};
        vecs[6]  = '{32'hFFFFF217, 7'h17, 3'd7, 7'h7F, 5'd31, 5'd31, 5'd4,  32'hFFFFF000, 4'b0011};
        vecs[7]  = '{32'hFFF100E7, 7'h67, 3'd0, 7'h7F, 5'd2,  5'd31, 5'd1,  32'hFFFFFFFF, 4'b1001};
        vecs[8]  = '{32'h0000A003, 7'h03, 3'd2, 7'h00, 5'd1,  5'd0,  5'd0,  32'h00000000, 4'b0001};
        vecs[9]  = '{32'hFFFFFFFF, 7'h7F, 3'd7, 7'h7F, 5'd31, 5'd31, 5'd31, 32'h00000000, 4'b0000};
        vecs[10] = '{32'h80002003, 7'h03, 3'd2, 7'h40, 5'd0,  5'd0,  5'd0,  32'hFFFFF800, 4'b0001};

        #2;
        for (int i = 0; i < 32; i++) dbg($sformatf("reset_x%0d", i), i[4:0], 32'h0);

        // decode table applied while reset holds the register file
        for (int i = 0; i < 11; i++) begin
            instruction = vecs[i].instr;
            #1;
            chk($sformatf("fields_%0d", i), {opcode, funct3, funct7, rs1, rs2, rd},
                {vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].s1, vecs[i].s2, vecs[i].d});
            chk($sformatf("imm_%0d", i), imm, vecs[i].im);
            chk($sformatf("ctrl_%0d", i), {28'b0, jump_sel, mem_we, op1_sel, op2_sel}, {28'b0, vecs[i].ctl});
        end

        @(negedge clk);
        reset = 1'b1;
        instruction = 32'h00500093; alu_out = 32'd5;
        dbg("addi_before_edge", 5'd1, 32'h0);
        step();
        dbg("addi_x1", 5'd1, 32'd5);

        instruction = 32'hFE20AE23; alu_out = 32'h55; data_mem = 32'h66;
        #1;
        chk("sw_rs1_data", rs1_data, 32'd5);
        chk("sw_rs2_data", rs2_data, 32'd0);
        step();
        dbg("sw_x1_kept", 5'd1, 32'd5);
        dbg("sw_x28_untouched", 5'd28, 32'h0);
        dbg("sw_x2_untouched", 5'd2, 32'h0);

        instruction = 32'h008000EF; pc_4 = 32'h104; alu_out = 32'h999;
        step();
        dbg("jal_x1_pc4", 5'd1, 32'h104);

        instruction = 32'h123452B7; alu_out = 32'h12345000; pc_4 = 32'h200;
        step();
        dbg("lui_x5", 5'd5, 32'h12345000);

        instruction = 32'h0000A003; data_mem = 32'hDEAD; alu_out = 32'h1;
        step();
        dbg("load_x0_zero", 5'd0, 32'h0);

        instruction = 32'h0000A183; data_mem = 32'hDEAD; alu_out = 32'h1;
        step();
        dbg("load_x3_mem", 5'd3, 32'hDEAD);

        instruction = 32'h00508333; alu_out = 32'h12345104;
        #1;
        chk("add_rs1_data", rs1_data, 32'h104);
        chk("add_rs2_data", rs2_data, 32'h12345000);
        step();
        dbg("add_x6_alu", 5'd6, 32'h12345104);

        // write pending to x1 while x1 is also read: no bypass before the edge
        instruction = 32'h00008093; alu_out = 32'h77;
        #1;
        chk("no_bypass_rs1", rs1_data, 32'h104);
        step();
        dbg("addi_x1_after", 5'd1, 32'h77);

        instruction = 32'hFE208CE3; alu_out = 32'hBAD;
        step();
        dbg("branch_no_write", 5'd25, 32'h0);

        instruction = 32'hFFFFFFFF; alu_out = 32'hBAD;
        step();
        dbg("unknown_no_write", 5'd31, 32'h0);

        debug_en = 1'b0;
        dbg("debug_off_x1", 5'd1, 32'h0);
        debug_en = 1'b1;
        dbg("debug_on_x1", 5'd1, 32'h77);

        // asynchronous clear mid-cycle
        instruction = 32'h002081B3; alu_out = 32'h0;
        #2;
        reset = 1'b0;
        dbg("async_clear_x3", 5'd3, 32'h0);
        chk("async_clear_rs1", rs1_data, 32'h0);
        debug_en = 1'b0;
        dbg("reset_debug_off", 5'd3, 32'h0);
        debug_en = 1'b1;

        instruction = 32'h03300193; alu_out = 32'h33;
        step();
        dbg("no_write_in_reset", 5'd3, 32'h0);

        @(negedge clk);
        reset = 1'b1;
        #1;
        dbg("release_before_edge", 5'd3, 32'h0);
        step();
        dbg("first_write_after_release", 5'd3, 32'h33);
        dbg("x1_still_cleared", 5'd1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
